separar_matricula: RTL and testbench

//   Inverse of the plate-packing path: accepts one packed 24-bit plate (matricula)
//   and emits its six 4-bit digits one at a time, most-significant nibble first.
//   m0 is matricula[23:20] and m5 is matricula[3:0].

---
 rtl/separar_matricula_pkg.sv | 15 +
 rtl/separar_matricula_if.sv | 40 ++++
 rtl/separar_matricula.sv | 75 +++++++
 tb/tb_separar_matricula.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/separar_matricula_pkg.sv
// Shared plate geometry and unpacker FSM states, imported by the
// packing and unpacking blocks alike.
package matricula_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int DIGIT_W    = 4;
    localparam int MAT_W      = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    typedef enum logic {
        IDLE  = 1'b0,
        ENVIA = 1'b1
    } estado_t;

endpackage

// File: rtl/separar_matricula_if.sv
// Plate-in / digit-out handshake bundle between the plate register,
// the unpacker and the per-digit consumer.
interface separar_matricula_if;
    import matricula_pkg::*;

    logic [MAT_W-1:0]   matricula;
    logic               mat_valid;
    logic               mat_ready;
    logic [DIGIT_W-1:0] digito;
    logic [IDX_W-1:0]   digito_idx;
    logic               digito_valid;
    logic               digito_ready;
    logic               fim;
    logic               ocupado;

    modport slave (
        input  matricula,
        input  mat_valid,
        output mat_ready,
        output digito,
        output digito_idx,
        output digito_valid,
        input  digito_ready,
        output fim,
        output ocupado
    );

    modport master (
        output matricula,
        output mat_valid,
        input  mat_ready,
        input  digito,
        input  digito_idx,
        input  digito_valid,
        output digito_ready,
        input  fim,
        input  ocupado
    );

endinterface

// File: rtl/separar_matricula.sv
// Splits a packed 24-bit plate into its six digits, most-significant first.
//   state | meaning
//   IDLE  | waiting for a plate, mat_ready high
//   ENVIA | presenting shreg's top nibble as the current digit
module separar_matricula
    import matricula_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    separar_matricula_if.slave bus
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    estado_t          state;
    estado_t          state_nxt;
    logic [MAT_W-1:0] shreg;
    logic [MAT_W-1:0] shreg_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             fim_q;
    logic             fim_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            fim_q <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            idx   <= idx_nxt;
            fim_q <= fim_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        fim_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mat_valid) begin
                    shreg_nxt = bus.matricula;
                    idx_nxt   = '0;
                    state_nxt = ENVIA;
                end
            end
            ENVIA: begin
                if (bus.digito_ready) begin
                    // Shifting in zeros also leaves digito at 0 once the plate is done.
                    shreg_nxt = {shreg[MAT_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
                    if (idx == IDX_LAST) begin
                        idx_nxt   = '0;
                        fim_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mat_ready    = (state == IDLE);
    assign bus.digito_valid = (state == ENVIA);
    assign bus.ocupado      = (state != IDLE);
    assign bus.digito       = shreg[MAT_W-1 -: DIGIT_W];
    assign bus.digito_idx   = idx;
    assign bus.fim          = fim_q;

endmodule

// File: tb/tb_separar_matricula.sv
// Directed bench for the plate unpacker: ordering, stalls, back-to-back
// plates, ignored input while busy and mid-plate reset.
module tb_separar_matricula;
    import matricula_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   ndig;
    int   nfim;

    separar_matricula_if bus ();

    separar_matricula dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dig(input string tag, input logic [3:0] d, input logic [2:0] i);
        chk({tag, ".digito"}, 32'(bus.digito), 32'(d));
        chk({tag, ".idx"}, 32'(bus.digito_idx), 32'(i));
        chk({tag, ".valid"}, 32'(bus.digito_valid), 32'd1);
        chk({tag, ".mat_ready"}, 32'(bus.mat_ready), 32'd0);
        chk({tag, ".ocupado"}, 32'(bus.ocupado), 32'd1);
        chk({tag, ".fim"}, 32'(bus.fim), 32'd0);
        if (bus.digito_valid === 1'b1) ndig++;
    endtask

    task automatic chk_idle(input string tag, input logic fim_e);
        chk({tag, ".valid"}, 32'(bus.digito_valid), 32'd0);
        chk({tag, ".mat_ready"}, 32'(bus.mat_ready), 32'd1);
        chk({tag, ".ocupado"}, 32'(bus.ocupado), 32'd0);
        chk({tag, ".fim"}, 32'(bus.fim), 32'(fim_e));
        if (bus.fim === 1'b1) nfim++;
    endtask

    task automatic chk_reset(input string tag);
        chk_idle(tag, 1'b0);
        chk({tag, ".digito"}, 32'(bus.digito), 32'd0);
        chk({tag, ".idx"}, 32'(bus.digito_idx), 32'd0);
    endtask

    logic [3:0] exp1 [6] = '{4'h1, 4'h2, 4'hA, 4'hB, 4'h3, 4'h4};

    initial begin
        checks = 0;
        errors = 0;
        ndig   = 0;
        nfim   = 0;
        rst_n  = 1'b0;
        bus.matricula    = '0;
        bus.mat_valid    = 1'b0;
        bus.digito_ready = 1'b0;

        // reset
        #1;
        chk_reset("rst_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_reset("rst_release");

        // 1: 12AB34 streamed with ready held high
        bus.matricula    = 24'h12AB34;
        bus.mat_valid    = 1'b1;
        bus.digito_ready = 1'b1;
        tick();
        bus.mat_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk_dig("t1", exp1[i], 3'(i));
            tick();
        end
        chk_idle("t1_fim", 1'b1);
        tick();
        chk_idle("t1_after", 1'b0);

        // 2: 987654 with a 3-cycle stall at idx 2
        bus.matricula = 24'h987654;
        bus.mat_valid = 1'b1;
        tick();
        bus.mat_valid = 1'b0;
        chk_dig("t2_d0", 4'h9, 3'd0);
        tick();
        chk_dig("t2_d1", 4'h8, 3'd1);
        tick();
        chk_dig("t2_d2", 4'h7, 3'd2);
        bus.digito_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk_dig("t2_stall", 4'h7, 3'd2);
        end
        bus.digito_ready = 1'b1;
        tick();
        chk_dig("t2_d3", 4'h6, 3'd3);
        tick();
        chk_dig("t2_d4", 4'h5, 3'd4);
        tick();
        chk_dig("t2_d5", 4'h4, 3'd5);
        tick();
        chk_idle("t2_fim", 1'b1);
        tick();

        // 3: back-to-back plates with mat_valid held high
        ndig = 0;
        nfim = 0;
        bus.matricula = 24'h111111;
        bus.mat_valid = 1'b1;
        tick();
        bus.matricula = 24'h222222;
        for (int i = 0; i < 6; i++) begin
            chk_dig("t3_p1", 4'h1, 3'(i));
            tick();
        end
        chk_idle("t3_fim1", 1'b1);
        tick();
        bus.mat_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk_dig("t3_p2", 4'h2, 3'(i));
            tick();
        end
        chk_idle("t3_fim2", 1'b1);
        chk("t3_ndig", 32'(ndig), 32'd12);
        chk("t3_nfim", 32'(nfim), 32'd2);
        tick();
        chk_idle("t3_after", 1'b0);

        // 4: FFFFFF offered while 000000 is in flight
        bus.matricula = 24'h000000;
        bus.mat_valid = 1'b1;
        tick();
        bus.matricula = 24'hFFFFFF;
        for (int i = 0; i < 6; i++) begin
            chk_dig("t4", 4'h0, 3'(i));
            if (i == 5) bus.mat_valid = 1'b0;
            tick();
        end
        chk_idle("t4_fim", 1'b1);
        tick();
        chk_reset("t4_not_captured");

        // 5: reset at idx 3 of ABCDEF
        bus.matricula = 24'hABCDEF;
        bus.mat_valid = 1'b1;
        tick();
        bus.mat_valid = 1'b0;
        chk_dig("t5_d0", 4'hA, 3'd0);
        tick();
        chk_dig("t5_d1", 4'hB, 3'd1);
        tick();
        chk_dig("t5_d2", 4'hC, 3'd2);
        tick();
        chk_dig("t5_d3", 4'hD, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("t5_rst_async");
        tick();
        chk_reset("t5_rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_reset("t5_release");
        bus.matricula = 24'h5A5A5A;
        bus.mat_valid = 1'b1;
        tick();
        bus.mat_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk_dig("t5_next", (i % 2 == 0) ? 4'h5 : 4'hA, 3'(i));
            tick();
        end
        chk_idle("t5_fim", 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
